flag_branch_unit: RTL and testbench
===================================

# flag_branch_unit

Consumer end of the ALU flag interface. Holds the architectural {N,V,Z} flag register, applies per-instruction flag write masks, and resolves branch condition codes against the flags. Produces a registered taken/not-taken result for the fetch/PC logic and keeps a saturating count of taken branches. Sits between the ALU flag outputs and the PC-update logic.

## Interface
Parameters:
- BYPASS, default 1: 1 means conditions see same-cycle flag writes; 0 means conditions see registered flags only.
- CNT_W, default 16: width of the taken-branch counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flag_in  in  3  ALU flags {N,V,Z}; Z at bit 0 is 1 when the ALU result is zero.
- flag_we  in  3  per-bit write mask, aligned with flag_in. XOR uses 3'b001; ADD/SUB use 3'b111; non-flag ops use 3'b000.
- stall  in  1  freezes the flag register and the branch result registers.
- flush  in  1  kills the branch being captured this cycle and clears the result.
- br_valid  in  1  a branch instruction is presented.
- br_ccc  in  3  condition code.
- cnt_clr  in  1  synchronous clear of the taken counter.
- flag_out  out  3  registered architectural flags {N,V,Z}.
- br_done  out  1  registered; a branch result is valid.
- br_taken  out  1  registered; meaningful only while br_done=1, otherwise 0.
- taken_cnt  out  CNT_W  saturating count of resolved taken branches.

## Operation
- **Flag register:** each bit i loads flag_in[i] when flag_we[i]=1 and stall=0. Bits with flag_we[i]=0 hold their value.
- **Effective flags (eff):**
  - BYPASS=1: eff[i] = flag_we[i] ? flag_in[i] : flag_out[i].
  - BYPASS=0: eff = flag_out.
- **Condition decode on eff (N, V, Z):**
  - 000 NE: !Z
  - 001 EQ: Z
  - 010 GT: !Z & !N
  - 011 LT: N
  - 100 GE: Z | (!Z & !N)
  - 101 LE: N | Z
  - 110 OV: V
  - 111 always taken
- **Result register:** a branch is accepted when br_valid=1, stall=0 and flush=0. On the next edge, br_done=1 and br_taken=cond.
- **No new branch:** if stall=0 and no branch is accepted, br_done and br_taken go to 0 on the next edge, so br_done is a single-cycle pulse per branch.
- **Stall:** with stall=1 and flush=0, flag_out, br_done and br_taken hold their values.
- **Flush:** with flush=1, br_done and br_taken go to 0 on the next edge, regardless of stall. The flag register still follows the stall/flag_we rules.
- **Counter:**
  - cnt_clr=1 sets taken_cnt to 0 on the next edge. It has priority over increment and ignores stall.
  - Otherwise taken_cnt increments by 1 at each edge where an accepted branch resolves taken.
  - The count saturates at all-ones and does not wrap.

## Timing
- **Reset (rst_n=0, asynchronous):** flag_out=3'b000, br_done=0, br_taken=0, taken_cnt=0. Takes effect immediately and overrides everything, including mid-stall or with a branch in flight.
- **Flag write latency:** 1 cycle from flag_we to flag_out.
- **Branch latency:** 1 cycle from accepted br_valid to br_done/br_taken.
- **Same-cycle write and branch:**
  - BYPASS=1: the branch sees the new flag values for the written bits.
  - BYPASS=0: the branch sees the old values.
- **Counter timing:** taken_cnt updates on the same edge that sets br_done=1 with br_taken=1.
- **Back-to-back branches:** a branch every cycle gives br_done=1 every cycle, with each br_taken reflecting its own branch.
- **Priority per edge:** rst_n > flush > stall > normal. For the counter: cnt_clr > increment.

## Test plan
- **Reset:** assert rst_n=0 mid-operation with flag_out=3'b111 and taken_cnt=5 -> all outputs 0 immediately, without waiting for a clock edge.
- **Masked write:** start from flag_out=3'b110; flag_in=3'b001 with flag_we=3'b001 -> flag_out=3'b111 next cycle. Then flag_in=3'b000 with flag_we=3'b111 -> 3'b000.
- **Condition sweep:** for each br_ccc value (0-7) and each of the 8 stored flag patterns (flag_we=0) -> br_taken matches the decode table. Example: flags 3'b100 with ccc=011 -> taken=1; flags 3'b100 with ccc=010 -> taken=0.
- **Bypass:** flag_out Z=0; in the same cycle flag_in Z=1, flag_we=3'b001, br_ccc=001:
  - BYPASS=1 -> br_taken=1.
  - BYPASS=0 -> br_taken=0.
- **Stall/flush:**
  - Branch accepted, then stall=1 for 3 cycles -> br_done stays 1 and taken_cnt increments only once.
  - Flush with br_valid=1 -> br_done=0 next cycle and taken_cnt unchanged.
- **Counter:** preload taken_cnt to 16'hFFFE; issue 3 taken ccc=111 branches -> count reads FFFF, FFFF, FFFF. Then cnt_clr=1 in the same cycle as a taken branch -> taken_cnt=0.

Source files
------------

// File: rtl/flag_branch_unit.sv
// flag_branch_unit
// Holds the architectural {N,V,Z} flag register fed by the ALU, resolves
// branch condition codes against those flags and hands a registered
// taken/not-taken result to the PC logic.  It also keeps a saturating
// count of taken branches.
module flag_branch_unit #(
    parameter int BYPASS = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       flag_in,
    input  logic [2:0]       flag_we,
    input  logic             stall,
    input  logic             flush,
    input  logic             br_valid,
    input  logic [2:0]       br_ccc,
    input  logic             cnt_clr,
    output logic [2:0]       flag_out,
    output logic             br_done,
    output logic             br_taken,
    output logic [CNT_W-1:0] taken_cnt
);

    // Condition code encodings
    localparam logic [2:0] CC_NE = 3'b000;
    localparam logic [2:0] CC_EQ = 3'b001;
    localparam logic [2:0] CC_GT = 3'b010;
    localparam logic [2:0] CC_LT = 3'b011;
    localparam logic [2:0] CC_GE = 3'b100;
    localparam logic [2:0] CC_LE = 3'b101;
    localparam logic [2:0] CC_OV = 3'b110;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [2:0]       flag_reg;
    logic [2:0]       flag_next;
    logic [2:0]       eff;
    logic             cond;
    logic             accept;
    logic             done_reg;
    logic             done_next;
    logic             taken_reg;
    logic             taken_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    // Per-bit flag update and effective-flag selection.  Each flag bit has
    // its own write enable, so the ALU can touch only the bits its opcode
    // defines.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_flag
            assign flag_next[gi] = (flag_we[gi] && !stall) ? flag_in[gi] : flag_reg[gi];
            if (BYPASS != 0) begin : g_byp
                // Forward this cycle's write so a branch right behind a
                // flag-setting op does not need a bubble.
                assign eff[gi] = flag_we[gi] ? flag_in[gi] : flag_reg[gi];
            end else begin : g_nobyp
                assign eff[gi] = flag_reg[gi];
            end
        end
    endgenerate

    // Condition decode against the effective {N,V,Z}
    always_comb begin
        cond = 1'b1;
        unique case (br_ccc)
            CC_NE:   cond = !eff[0];
            CC_EQ:   cond = eff[0];
            CC_GT:   cond = !eff[0] && !eff[2];
            CC_LT:   cond = eff[2];
            CC_GE:   cond = eff[0] || (!eff[0] && !eff[2]);
            CC_LE:   cond = eff[2] || eff[0];
            CC_OV:   cond = eff[1];
            default: cond = 1'b1;
        endcase
    end

    assign accept = br_valid && !stall && !flush;

    // Result next-state: flush wins over stall; stall holds; otherwise the
    // result is a one-cycle pulse per accepted branch.
    always_comb begin
        done_next  = done_reg;
        taken_next = taken_reg;
        if (flush) begin
            done_next  = 1'b0;
            taken_next = 1'b0;
        end else if (!stall) begin
            done_next  = accept;
            taken_next = accept && cond;
        end
    end

    // Counter next-state: clear beats increment, and the count sticks at
    // all-ones.  A held (stalled) result is not counted again because only
    // accepted branches increment.
    always_comb begin
        cnt_next = cnt_reg;
        if (cnt_clr) begin
            cnt_next = '0;
        end else if (accept && cond && (cnt_reg != CNT_MAX)) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_reg  <= 3'b000;
            done_reg  <= 1'b0;
            taken_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            flag_reg  <= flag_next;
            done_reg  <= done_next;
            taken_reg <= taken_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign flag_out  = flag_reg;
    assign br_done   = done_reg;
    assign br_taken  = taken_reg;
    assign taken_cnt = cnt_reg;

endmodule

// File: tb/tb_flag_branch_unit.sv
// tb_flag_branch_unit
// Directed stimulus with hand-computed expectations.  Each accepted branch
// pushes its expected {taken, count} into a queue; a monitor pops and
// compares whenever the DUT presents a fresh br_done.  A second instance
// with BYPASS=0 is driven in parallel for the forwarding comparison.
module tb_flag_branch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  flag_in;
    logic [2:0]  flag_we;
    logic        stall;
    logic        flush;
    logic        br_valid;
    logic [2:0]  br_ccc;
    logic        cnt_clr;

    logic [2:0]  flag_out,  flag_out0;
    logic        br_done,   br_done0;
    logic        br_taken,  br_taken0;
    logic [15:0] taken_cnt, taken_cnt0;

    typedef struct {
        logic        t;
        logic [15:0] c;
    } sb_t;

    sb_t         q[$];
    int          errors = 0;
    int          checks = 0;
    logic        mon_en = 1'b1;
    logic        stall_q = 1'b0;
    logic [15:0] model_cnt = 16'h0;

    // Hand-derived decode table: bit f of cc_mask[ccc] is taken for flags f={N,V,Z}
    logic [7:0]  cc_mask [8];

    always #5 clk = ~clk;

    flag_branch_unit #(.BYPASS(1), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .flag_in(flag_in), .flag_we(flag_we),
        .stall(stall), .flush(flush), .br_valid(br_valid), .br_ccc(br_ccc),
        .cnt_clr(cnt_clr), .flag_out(flag_out), .br_done(br_done),
        .br_taken(br_taken), .taken_cnt(taken_cnt)
    );

    flag_branch_unit #(.BYPASS(0), .CNT_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .flag_in(flag_in), .flag_we(flag_we),
        .stall(stall), .flush(flush), .br_valid(br_valid), .br_ccc(br_ccc),
        .cnt_clr(cnt_clr), .flag_out(flag_out0), .br_done(br_done0),
        .br_taken(br_taken0), .taken_cnt(taken_cnt0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // One clock of stimulus; returns at posedge+1
    task automatic cyc(input logic [2:0] fin, input logic [2:0] fwe, input logic bv,
                       input logic [2:0] ccc, input logic st, input logic fl,
                       input logic clr, input logic exp_t);
        logic acc;
        flag_in  = fin;
        flag_we  = fwe;
        br_valid = bv;
        br_ccc   = ccc;
        stall    = st;
        flush    = fl;
        cnt_clr  = clr;
        acc = bv && !st && !fl;
        if (clr) model_cnt = 16'h0;
        else if (acc && exp_t && model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'h1;
        if (acc && mon_en) q.push_back('{t: exp_t, c: model_cnt});
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Remember whether the edge that produced the current outputs was stalled
    always @(posedge clk) stall_q = stall;

    // Monitor: compare each freshly presented branch result against the queue
    always @(negedge clk) begin
        if (rst_n && mon_en && br_done && !stall_q) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: br_done=1 with no expected entry, taken=%0b cnt=%0h",
                         br_taken, taken_cnt);
            end else begin
                sb_t e;
                e = q.pop_front();
                if (br_taken !== e.t || taken_cnt !== e.c) begin
                    errors++;
                    $display("FAIL sb_branch: taken=%0b cnt=%0h expected taken=%0b cnt=%0h",
                             br_taken, taken_cnt, e.t, e.c);
                end else begin
                    $display("ok   sb_branch: taken=%0b cnt=%0h", br_taken, taken_cnt);
                end
            end
        end
    end

    initial begin
        logic [2:0] held;
        cc_mask[0] = 8'h55;  // NE
        cc_mask[1] = 8'hAA;  // EQ
        cc_mask[2] = 8'h05;  // GT
        cc_mask[3] = 8'hF0;  // LT
        cc_mask[4] = 8'hAF;  // GE
        cc_mask[5] = 8'hFA;  // LE
        cc_mask[6] = 8'hCC;  // OV
        cc_mask[7] = 8'hFF;  // always

        rst_n = 1'b0; flag_in = 3'b000; flag_we = 3'b000; stall = 1'b0;
        flush = 1'b0; br_valid = 1'b0; br_ccc = 3'b000; cnt_clr = 1'b0;
        #3;
        chk("reset_state", {flag_out, br_done, br_taken, taken_cnt}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Masked writes
        cyc(3'b110, 3'b111, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("flag_preset", flag_out, 3'b110);
        cyc(3'b001, 3'b001, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("mask_z_only", flag_out, 3'b111);
        cyc(3'b000, 3'b111, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("mask_all", flag_out, 3'b000);

        // Asynchronous reset mid-operation with flags=111 and count=5
        cyc(3'b111, 3'b111, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)
            cyc(3'b000, 3'b000, 1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("pre_reset_cnt", {flag_out, taken_cnt}, {3'b111, 16'd5});
        cyc(3'b000, 3'b000, 1'b1, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", {flag_out, br_done, br_taken, taken_cnt}, 32'h0);
        model_cnt = 16'h0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        stall = 1'b0;

        // Condition sweep over stored flags
        for (int f = 0; f < 8; f++) begin
            cyc(3'(f), 3'b111, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
            for (int c = 0; c < 8; c++)
                cyc(3'b000, 3'b000, 1'b1, 3'(c), 1'b0, 1'b0, 1'b0, cc_mask[c][f]);
        end
        idle();

        // Forwarding: Z written 1 in the branch cycle, EQ
        cyc(3'b000, 3'b111, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(3'b001, 3'b001, 1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("nobypass_eq_old", {br_done0, br_taken0}, 2'b10);
        // Z written 0 while stored Z=1, EQ
        cyc(3'b000, 3'b001, 1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("nobypass_eq_old2", {br_done0, br_taken0}, 2'b11);
        idle();

        // Stall holds result and flags; count only once
        held = flag_out;
        cyc(3'b000, 3'b000, 1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc(3'b010, 3'b111, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
            chk($sformatf("stall_hold_%0d", i), {flag_out, br_done, br_taken, taken_cnt},
                {held, 1'b1, 1'b1, model_cnt});
        end
        idle();
        chk("stall_release", br_done, 1'b0);

        // Flush kills the captured branch
        cyc(3'b000, 3'b000, 1'b1, 3'b111, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("flush_kill", {br_done, taken_cnt}, {1'b0, model_cnt});
        // Flush overrides a held result under stall
        cyc(3'b000, 3'b000, 1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(3'b000, 3'b000, 1'b1, 3'b111, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("flush_over_stall", {br_done, br_taken}, 2'b00);
        idle();

        // Counter: preload to FFFE, saturate, then clear beats increment
        cyc(3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
        mon_en = 1'b0;
        for (int i = 0; i < 65534; i++)
            cyc(3'b000, 3'b000, 1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 1'b1);
        idle();
        mon_en = 1'b1;
        chk("cnt_preload", taken_cnt, 16'hFFFE);
        for (int i = 0; i < 3; i++)
            cyc(3'b000, 3'b000, 1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("cnt_saturated", taken_cnt, 16'hFFFF);
        cyc(3'b000, 3'b000, 1'b1, 3'b111, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("cnt_clear_priority", taken_cnt, 16'h0);
        idle();
        idle();

        chk("sb_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
